// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - stage_time_e : Tuse/Tnew encoding (cycles until a value is needed or ready)
//   - MDU busy-window defaults
//   - architectural zero register
//   - later_than() : Tnew/Tuse comparison used by the hazard detector
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } stage_time_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

  // True when the producer's result arrives after the consumer needs it.
  function automatic logic later_than(input logic [1:0] tnew, input logic [1:0] tuse);
    return tnew > tuse;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// MDU start/busy tracker.
//   clk, reset     : clock, synchronous active-low reset
//   md_start_E     : E stage holds mult/multu/div/divu
//   md_is_div_E    : that op is a divide
//   mem_wait       : global freeze (blocks acceptance only)
//   enable_E       : E_M register enable; a moving E stage retires start_taken
//   accept         : one-cycle start of the MDU for the E instruction
//   md_busy        : MDU busy window active
module md_busy_tracker
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_is_div_E,
  input  logic mem_wait,
  input  logic enable_E,
  output logic accept,
  output logic md_busy
);

  logic [CNT_W-1:0] busy_cnt;
  logic             start_taken;

  // start_taken remembers that the current E instruction already fired, so a
  // frozen E stage holding the same mult/div never produces a second pulse.
  assign accept  = md_start_E && !start_taken && !mem_wait;
  assign md_busy = (busy_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cnt    <= '0;
      start_taken <= 1'b0;
    end else begin
      // The MDU runs independently of the freeze, so counting continues.
      if (accept)
        busy_cnt <= md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - CNT_W'(1);

      if (accept)
        start_taken <= 1'b1;
      else if (enable_E)
        start_taken <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
//   clk, reset           : clock, synchronous active-low reset
//   rs_D/rt_D            : D-stage source registers, use_*_D qualify them
//   tuse_rs_D/tuse_rt_D  : cycles until each source is needed
//   writeReg_E/tnew_E    : E-stage destination and its result latency
//   writeReg_M/tnew_M    : M-stage destination and its result latency
//   md_use_D             : D instruction touches the MDU
//   md_start_E/md_is_div_E : E holds an MDU start op / it is a divide
//   mem_wait             : data memory not ready; freeze the pipe
//   enable_F/D/E/W       : pipeline register enables
//   flush_E              : D_E bubble insert
//   md_go, md_busy       : MDU start pulse, MDU busy window
//   stall_cnt            : saturating count of hazard-stall cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        use_rs_D,
  input  logic        use_rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  writeReg_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  writeReg_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_use_D,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        mem_wait,
  output logic        enable_F,
  output logic        enable_D,
  output logic        flush_E,
  output logic        enable_E,
  output logic        enable_W,
  output logic        md_go,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic raw_rs, raw_rt, raw_stall, md_stall, stall, accept;

  assign raw_rs = use_rs_D && (rs_D != REG_ZERO) &&
                  (((rs_D == writeReg_E) && later_than(tnew_E, tuse_rs_D)) ||
                   ((rs_D == writeReg_M) && later_than(tnew_M, tuse_rs_D)));
  assign raw_rt = use_rt_D && (rt_D != REG_ZERO) &&
                  (((rt_D == writeReg_E) && later_than(tnew_E, tuse_rt_D)) ||
                   ((rt_D == writeReg_M) && later_than(tnew_M, tuse_rt_D)));
  assign raw_stall = raw_rs || raw_rt;

  // An MDU op in D must wait while the unit is busy, including the cycle the
  // E-stage op is being accepted (busy only shows from the next cycle).
  assign md_stall = md_use_D && (md_busy || accept);
  assign stall    = raw_stall || md_stall;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_tracker (
    .clk         (clk),
    .reset       (reset),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .mem_wait    (mem_wait),
    .enable_E    (enable_E),
    .accept      (accept),
    .md_busy     (md_busy)
  );

  // During reset every register is enabled so it captures its own reset value.
  always_comb begin
    enable_F = 1'b1;
    enable_D = 1'b1;
    flush_E  = 1'b0;
    enable_E = 1'b1;
    enable_W = 1'b1;
    md_go    = 1'b0;
    if (reset) begin
      enable_F = !stall && !mem_wait;
      enable_D = !stall && !mem_wait;
      flush_E  = stall && !mem_wait;
      enable_E = !mem_wait;
      enable_W = !mem_wait;
      md_go    = accept;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall && !mem_wait && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, writeReg_E, writeReg_M;
  logic        use_rs_D, use_rt_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_use_D, md_start_E, md_is_div_E, mem_wait;
  logic        enable_F, enable_D, flush_E, enable_E, enable_W, md_go, md_busy;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  bit run    = 0;

  // Reference model state: remaining MDU busy cycles, whether the current
  // E instruction has already started the MDU, and the stall counter.
  int     m_busy  = 0;
  bit     m_taken = 0;
  longint m_cnt   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .writeReg_E(writeReg_E), .tnew_E(tnew_E),
    .writeReg_M(writeReg_M), .tnew_M(tnew_M),
    .md_use_D(md_use_D), .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
    .mem_wait(mem_wait),
    .enable_F(enable_F), .enable_D(enable_D), .flush_E(flush_E),
    .enable_E(enable_E), .enable_W(enable_W),
    .md_go(md_go), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit src_hazard(input int r, input bit used, input int tuse);
    if (!used || r == 0) return 0;
    return (r == int'(writeReg_E) && int'(tnew_E) > tuse) ||
           (r == int'(writeReg_M) && int'(tnew_M) > tuse);
  endfunction

  function automatic bit m_accept();
    return md_start_E && !m_taken && !mem_wait;
  endfunction

  function automatic bit m_stall();
    return src_hazard(int'(rs_D), use_rs_D, int'(tuse_rs_D)) ||
           src_hazard(int'(rt_D), use_rt_D, int'(tuse_rt_D)) ||
           (md_use_D && (m_busy > 0 || m_accept()));
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 0; m_taken = 0; m_cnt = 0;
    end else begin
      bit acc, st;
      acc = m_accept();
      st  = m_stall();
      if (st && !mem_wait && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (acc) m_busy = md_is_div_E ? 10 : 5;
      else if (m_busy > 0) m_busy = m_busy - 1;
      if (acc) m_taken = 1;
      else if (!mem_wait) m_taken = 0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      bit st, rst_act;
      st = m_stall();
      rst_act = !reset;
      chk("enable_F", enable_F, rst_act ? 1 : (!st && !mem_wait));
      chk("enable_D", enable_D, rst_act ? 1 : (!st && !mem_wait));
      chk("flush_E",  flush_E,  rst_act ? 0 : (st && !mem_wait));
      chk("enable_E", enable_E, rst_act ? 1 : !mem_wait);
      chk("enable_W", enable_W, rst_act ? 1 : !mem_wait);
      chk("md_go",    md_go,    rst_act ? 0 : m_accept());
      chk("md_busy",  md_busy,  m_busy > 0);
      chk("stall_cnt", stall_cnt, m_cnt);
    end
  end

  task automatic idle();
    rs_D = 0; rt_D = 0; use_rs_D = 0; use_rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0;
    writeReg_E = 0; tnew_E = 0; writeReg_M = 0; tnew_M = 0;
    md_use_D = 0; md_start_E = 0; md_is_div_E = 0; mem_wait = 0;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 0;
    idle();
    adv(); adv();
    run = 1;
    // Reset state; a hazard is presented but must be masked.
    rs_D = 8; use_rs_D = 1; tuse_rs_D = 1; writeReg_E = 8; tnew_E = 2;
    @(negedge clk);
    chk("rst_enF", enable_F, 1); chk("rst_flush", flush_E, 0);
    chk("rst_cnt", stall_cnt, 0); chk("rst_busy", md_busy, 0);
    adv();
    reset = 1;

    // Load-use: one stall cycle, then lw in M no longer stalls.
    @(negedge clk);
    chk("lu_enF", enable_F, 0); chk("lu_enD", enable_D, 0); chk("lu_flush", flush_E, 1);
    adv();
    writeReg_E = 0; tnew_E = 0; writeReg_M = 8; tnew_M = 1;
    @(negedge clk);
    chk("lu_next_enF", enable_F, 1); chk("lu_cnt", stall_cnt, 1);
    adv();

    // $0 destination never stalls.
    idle(); use_rs_D = 1; tnew_E = 2;
    @(negedge clk);
    chk("zero_enF", enable_F, 1); chk("zero_flush", flush_E, 0);
    adv();

    // rt hazard against M with tuse 0.
    idle(); rt_D = 5; use_rt_D = 1; writeReg_M = 5; tnew_M = 1;
    @(negedge clk);
    chk("rtM_flush", flush_E, 1);
    adv();
    // tnew == tuse: forwarding covers it.
    idle(); rs_D = 9; use_rs_D = 1; tuse_rs_D = 1; writeReg_E = 9; tnew_E = 1;
    @(negedge clk);
    chk("eq_enF", enable_F, 1); chk("eq_cnt", stall_cnt, 2);
    adv();

    // mult accepted at cycle 0 with mfhi in D.
    idle(); md_start_E = 1; md_use_D = 1;
    @(negedge clk);
    chk("mul_go0", md_go, 1); chk("mul_enF0", enable_F, 0);
    adv();
    md_start_E = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("mul_go", md_go, 0); chk("mul_busy", md_busy, 1); chk("mul_enD", enable_D, 0);
      adv();
    end
    @(negedge clk);
    chk("mul_done_busy", md_busy, 0); chk("mul_done_enF", enable_F, 1);
    chk("mul_cnt", stall_cnt, 8);
    adv();

    // div held in E during a 4-cycle freeze: single pulse after the freeze.
    idle(); md_start_E = 1; md_is_div_E = 1; mem_wait = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dw_go", md_go, 0); chk("dw_enF", enable_F, 0); chk("dw_enE", enable_E, 0);
      chk("dw_enW", enable_W, 0); chk("dw_flush", flush_E, 0);
      adv();
    end
    mem_wait = 0;
    @(negedge clk);
    chk("dw_go4", md_go, 1);
    adv();
    md_start_E = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dw_busy", md_busy, 1);
      adv();
    end
    @(negedge clk);
    chk("dw_busy_end", md_busy, 0);
    adv();

    // Freeze right after an accept with the op still in E: no second pulse.
    idle(); md_start_E = 1;
    adv();
    mem_wait = 1;
    adv(); adv();
    mem_wait = 0;
    @(negedge clk);
    chk("frz_go", md_go, 0);
    adv();
    idle();
    repeat (5) adv();

    // Reset mid-operation while busy_cnt == 7 and D is stalled.
    md_start_E = 1; md_is_div_E = 1;
    adv();
    md_start_E = 0; md_use_D = 1;
    adv(); adv(); adv();
    reset = 0;
    @(negedge clk);
    chk("mr_enF", enable_F, 1); chk("mr_flush", flush_E, 0); chk("mr_busy_pre", md_busy, 1);
    adv();
    @(negedge clk);
    chk("mr_busy", md_busy, 0); chk("mr_cnt", stall_cnt, 0);
    adv();
    reset = 1;
    idle();
    adv();

    // Saturation of the stall counter.
    rs_D = 3; use_rs_D = 1; tuse_rs_D = 0; writeReg_E = 3; tnew_E = 2;
    force dut.stall_cnt = 32'hFFFF_FFFD;
    m_cnt = 64'hFFFF_FFFD;
    #1 release dut.stall_cnt;
    adv();
    @(negedge clk);
    chk("sat_fe", stall_cnt, 64'hFFFF_FFFE);
    repeat (4) adv();
    @(negedge clk);
    chk("sat_ff", stall_cnt, 64'hFFFF_FFFF);
    adv();

    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable inputs of the F, D_E, E_M and M_W pipeline registers, plus a bubble (flush) for D_E.
- Detects load-use/RAW hazards with Tuse/Tnew comparison and tracks the multi-cycle mult/div unit (MDU) busy window.
- Issues a one-shot MDU start pulse and honours a global memory-wait freeze.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu is accepted
DIV_CYCLES, 10, busy cycles after a div/divu is accepted
CNT_W, 4, width of MDU busy counter (must hold DIV_CYCLES)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset (0 = reset)
rs_D  in  5  source register rs of instruction in D
rt_D  in  5  source register rt of instruction in D
use_rs_D  in  1  D instruction reads rs
use_rt_D  in  1  D instruction reads rt
tuse_rs_D  in  2  cycles until rs is needed (0 = in D, 1 = in E)
tuse_rt_D  in  2  cycles until rt is needed
writeReg_E  in  5  destination of instruction in E (0 = none)
tnew_E  in  2  cycles until E result is forwardable
writeReg_M  in  5  destination of instruction in M
tnew_M  in  2  cycles until M result is forwardable
md_use_D  in  1  D instruction touches MDU (mult/div/mfhi/mflo/mthi/mtlo)
md_start_E  in  1  E holds mult/div/multu/divu
md_is_div_E  in  1  E MDU op is a divide
mem_wait  in  1  data memory not ready; freeze whole pipe
enable_F  out  1  PC/F_D register enable
enable_D  out  1  D_E register enable
flush_E  out  1  D_E bubble insert (drives D_E clear)
enable_E  out  1  E_M register enable
enable_W  out  1  M_W register enable
md_go  out  1  one-cycle MDU start pulse
md_busy  out  1  MDU busy window active
stall_cnt  out  32  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset==0 at posedge): busy_cnt=0, start_taken=0, stall_cnt=0. While reset==0, combinationally force enable_F/D/E/W=1, flush_E=0, md_go=0, so pipeline registers capture their own reset.
- RAW stall: for rs: use_rs_D && rs_D!=0 && ((rs_D==writeReg_E && tnew_E>tuse_rs_D) || (rs_D==writeReg_M && tnew_M>tuse_rs_D)). Identical term for rt. Register 0 never stalls.
- MDU accept: accept = md_start_E && !start_taken && !mem_wait. md_go = accept.
  - At the accept edge: busy_cnt <= md_is_div_E ? DIV_CYCLES : MULT_CYCLES, and start_taken <= 1.
  - start_taken clears on any edge with enable_E=1 and no accept. This guarantees exactly one md_go per E-stage instruction even when frozen.
- busy_cnt: decrements by 1 each cycle while nonzero. It decrements even during mem_wait, because the MDU runs independently. md_busy = (busy_cnt!=0).
- MDU stall: md_use_D && (md_busy || accept).
- stall = raw_stall || md_stall.
- Outputs when reset==1:
  - enable_F = enable_D = !stall && !mem_wait
  - flush_E = stall && !mem_wait
  - enable_E = enable_W = !mem_wait
  - mem_wait dominates: no bubble is inserted while frozen.
- stall_cnt: +1 on each edge with stall && !mem_wait; saturates at 32'hFFFF_FFFF.
- Latency: all outputs except md_busy/stall_cnt are combinational from inputs plus registered state, with zero-cycle response.
- Simultaneous accept and counter nonzero cannot occur legally, since D stalls MDU ops while busy. If it does occur, accept reloads the counter.

Decomposition:
- Shared package/header: Tuse/Tnew encodings (T0/T1/T2), MULT_CYCLES/DIV_CYCLES defaults, register-0 constant.
- One sub-module, md_busy_tracker: counter, start_taken, md_go, md_busy.
- Hazard compare stays inline.

Test Plan:
- Load-use: lw $8 in E (writeReg_E=8, tnew_E=2), addu reading $8 in D (tuse=1) -> one cycle enable_F=enable_D=0, flush_E=1, stall_cnt=1; next cycle (lw in M, tnew_M=1) no stall.
- $0 destination: writeReg_E=0, rs_D=0, use_rs_D=1, tnew_E=2 -> no stall, enables all 1.
- mult accepted cycle 0 with mfhi in D -> md_go=1 only at cycle 0, md_busy=1 cycles 1..5, D stalls cycles 0..5, proceeds cycle 6, stall_cnt=6.
- div with mem_wait=1 for cycles 0..3 while md_start_E held -> md_go only at cycle 4 (single pulse), then md_busy=1 for 10 cycles; all enables 0 during wait, flush_E=0.
- Reset mid-operation: reset=0 while busy_cnt=7 and stall asserted -> next edge busy_cnt=0, md_busy=0, stall_cnt=0; during reset all enables=1, flush_E=0.
- Saturation: preload stall_cnt near max (force), hold stall -> stays 32'hFFFF_FFFF.
